tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive-side counterpart of the team's 4:1 channel multiplexer.
- Takes a time-division-multiplexed stream of WIDTH-bit samples, one channel per beat, in slot order 0,1,2,3 repeating, with a frame_sync marker on slot 0.
- Tracks the slot position, acquires and maintains frame lock, and distributes each complete frame to four parallel channel outputs with a one-cycle frame_valid strobe.
- Sits between the serial link front-end and the per-channel consumers.

Parameters:
- WIDTH, 8: bits per channel sample.
- MISS_MAX, 3: consecutive missing slot-0 syncs tolerated in LOCKED before lock is dropped (range 1..15).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  TDM sample for the current slot.
- din_valid  input  1  beat qualifier; when 0, din and frame_sync are ignored and no state changes.
- frame_sync  input  1  marks the current beat as slot 0; only meaningful with din_valid=1.
- ch_data  output  4*WIDTH  registered frame; channel k in bits [k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse when ch_data is updated.
- slot  output  2  slot index the next accepted beat will occupy.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on a frame_sync at a non-zero expected slot.

Behaviour:
- Reset, asynchronous, active-high: state=HUNT, slot=0, shadow regs=0, ch_data=0, frame_valid=0, locked=0, sync_err=0, miss_cnt=0. Reset mid-frame discards the partial frame.
- Accepted beat: din_valid=1 at a rising edge. slot increments by 1 per accepted beat and wraps from 3 to 0.
- Slots 0-2: din is written to shadow[slot]. Slot 3: ch_data <= {din, shadow[2], shadow[1], shadow[0]}.
- Latency: ch_data and frame_valid change at the same edge that accepts the slot-3 beat, so they are visible in the following cycle.
- HUNT:
  - Beats without frame_sync are dropped; slot holds 0.
  - Beat with frame_sync: captured as slot 0, slot<=1, go to SYNC.
- SYNC:
  - Beats are collected; ch_data is updated at slot 3, but frame_valid stays 0.
  - Beat at expected slot 0 with frame_sync: go to LOCKED; this frame is delivered with frame_valid.
  - Beat at expected slot 0 without frame_sync: return to HUNT; the beat is dropped.
  - frame_sync at expected slot 1..3: sync_err pulse, realign (beat stored as slot 0, slot<=1), remain in SYNC.
- LOCKED:
  - Every slot-3 beat updates ch_data and pulses frame_valid (flywheel: a frame is delivered even if its sync was missing).
  - Slot 0 with frame_sync: miss_cnt<=0.
  - Slot 0 without frame_sync: miss_cnt++. When miss_cnt reaches MISS_MAX, go to HUNT and clear miss_cnt; that beat is dropped and no frame_valid is generated for the partial frame.
  - frame_sync at slot 1..3: sync_err pulse, realign as slot 0, go to SYNC, miss_cnt<=0; the partial frame is discarded.
- sync_err and frame_valid are never both asserted for the same beat, because a realign beat is never slot 3.
- din_valid=0 for any number of cycles: all state holds; frame_valid and sync_err are 0.
- locked is a registered decode of state and changes in the cycle after the transition edge.

Decomposition:
- Shared package tdm_pkg:
  - NCH=4 and SLOT_W=2.
  - State enum {HUNT, SYNC, LOCKED}.
  - Channel slice helper constant.
- Sub-module tdm_sync_fsm:
  - Owns state, slot counter, miss_cnt, sync_err.
  - Outputs slot, store_en, deliver, and drop to the datapath.
- Top level holds the shadow registers and ch_data.

Test Plan:
- Lock acquisition:
  - Stimulus: reset, then continuous beats din=0x10,0x11,0x12,0x13 with frame_sync on 0x10, repeated for 3 frames.
  - Response: first frame gives no frame_valid. locked=1 after the second sync. frame_valid pulses on frames 2 and 3, with ch_data=0x13121110.
- Gapped stream:
  - Stimulus: same stream as the lock-acquisition test, with din_valid=0 for 2 cycles between each beat.
  - Response: identical ch_data and frame_valid count. slot holds its value during the gaps.
- Flywheel and lock loss (MISS_MAX=3):
  - Stimulus: when locked, remove frame_sync for 2 frames.
  - Response: frames still delivered, locked=1.
  - Stimulus: then remove frame_sync for a third consecutive frame.
  - Response: at that slot-0 beat, state=HUNT and locked=0 one cycle later. No further frame_valid until reacquisition.
- Misplaced sync:
  - Stimulus: while locked, frame_sync on the slot-2 beat.
  - Response: sync_err pulses once, the partial frame is not delivered, and state=SYNC.
  - Stimulus: next correctly placed sync.
  - Response: relocks.
- Reset mid-frame:
  - Stimulus: rst asserted asynchronously (between clock edges) after the slot-1 beat.
  - Response: all outputs are 0 immediately, state=HUNT. After release, the first frame_sync restarts at slot 0 with no stale shadow data in ch_data.
- Width check (WIDTH=1):
  - Stimulus: bit pattern 1,0,1,1 with sync on the first bit.
  - Response: ch_data=4'b1101 after lock.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants, state encoding and channel slicing helper for the 4-channel TDM receiver.
package tdm_pkg;

    localparam int NCH    = 4;
    localparam int SLOT_W = 2;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NCH - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Low bit of channel k inside a packed frame of NCH channels.
    function automatic int ch_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame-lock state machine: tracks slot position, sync misses and misplaced syncs,
// and tells the datapath where to store each beat and when a frame is complete.
module tdm_sync_fsm
    import tdm_pkg::*;
#(
    parameter int MISS_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_sync,
    output logic [SLOT_W-1:0] o_slot,
    output logic [SLOT_W-1:0] o_wr_slot,
    output logic              o_store_en,
    output logic              o_load,
    output logic              o_deliver,
    output logic              o_drop,
    output logic              o_locked,
    output logic              o_sync_err
);

    localparam logic [3:0] MISS_LAST = 4'(MISS_MAX - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [SLOT_W-1:0] r_slot;
    logic [SLOT_W-1:0] w_slot_next;
    logic [3:0]        r_miss;
    logic [3:0]        w_miss_next;
    logic              r_locked;
    logic              r_sync_err;
    logic              w_sync_err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= HUNT;
            r_slot     <= '0;
            r_miss     <= '0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_slot     <= w_slot_next;
            r_miss     <= w_miss_next;
            r_locked   <= (r_state == LOCKED);
            r_sync_err <= w_sync_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_slot_next     = r_slot;
        w_miss_next     = r_miss;
        w_sync_err_next = 1'b0;
        o_wr_slot       = r_slot;
        o_store_en      = 1'b0;
        o_load          = 1'b0;
        o_deliver       = 1'b0;
        o_drop          = 1'b0;

        if (i_valid) begin
            case (r_state)
                HUNT: begin
                    if (i_sync) begin
                        o_store_en   = 1'b1;
                        o_wr_slot    = '0;
                        w_slot_next  = SLOT_W'(1);
                        w_state_next = SYNC;
                    end else begin
                        o_drop = 1'b1;
                    end
                end

                SYNC: begin
                    if (r_slot == '0) begin
                        if (i_sync) begin
                            o_store_en   = 1'b1;
                            w_slot_next  = SLOT_W'(1);
                            w_miss_next  = '0;
                            w_state_next = LOCKED;
                        end else begin
                            o_drop       = 1'b1;
                            w_state_next = HUNT;
                        end
                    end else if (i_sync) begin
                        // Misplaced sync: treat this beat as the start of a new frame.
                        w_sync_err_next = 1'b1;
                        o_store_en      = 1'b1;
                        o_wr_slot       = '0;
                        w_slot_next     = SLOT_W'(1);
                    end else if (r_slot == SLOT_LAST) begin
                        o_load      = 1'b1;
                        w_slot_next = '0;
                    end else begin
                        o_store_en  = 1'b1;
                        w_slot_next = r_slot + SLOT_W'(1);
                    end
                end

                LOCKED: begin
                    if (r_slot == '0) begin
                        if (i_sync) begin
                            o_store_en  = 1'b1;
                            w_slot_next = SLOT_W'(1);
                            w_miss_next = '0;
                        end else if (r_miss == MISS_LAST) begin
                            o_drop       = 1'b1;
                            w_miss_next  = '0;
                            w_state_next = HUNT;
                        end else begin
                            // Flywheel: keep framing on the expected position.
                            o_store_en  = 1'b1;
                            w_slot_next = SLOT_W'(1);
                            w_miss_next = r_miss + 4'd1;
                        end
                    end else if (i_sync) begin
                        w_sync_err_next = 1'b1;
                        o_store_en      = 1'b1;
                        o_wr_slot       = '0;
                        w_slot_next     = SLOT_W'(1);
                        w_miss_next     = '0;
                        w_state_next    = SYNC;
                    end else if (r_slot == SLOT_LAST) begin
                        o_load      = 1'b1;
                        o_deliver   = 1'b1;
                        w_slot_next = '0;
                    end else begin
                        o_store_en  = 1'b1;
                        w_slot_next = r_slot + SLOT_W'(1);
                    end
                end

                default: begin
                    w_state_next = HUNT;
                    w_slot_next  = '0;
                    w_miss_next  = '0;
                end
            endcase
        end
    end

    assign o_slot     = r_slot;
    assign o_locked   = r_locked;
    assign o_sync_err = r_sync_err;

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM demultiplexer: shadow-buffers slots 0..2 and publishes a whole
// frame on ch_data when the slot-3 beat arrives, under control of the lock FSM.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MISS_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [NCH*WIDTH-1:0] ch_data,
    output logic                 frame_valid,
    output logic [SLOT_W-1:0]    slot,
    output logic                 locked,
    output logic                 sync_err
);

    logic [SLOT_W-1:0]    w_wr_slot;
    logic                 w_store_en;
    logic                 w_load;
    logic                 w_deliver;
    logic                 w_drop;
    logic [NCH-2:0]       w_wr_hit;
    logic [NCH*WIDTH-1:0] w_frame;

    logic [WIDTH-1:0]     r_shadow [NCH-1];
    logic [NCH*WIDTH-1:0] r_ch_data;
    logic                 r_frame_valid;

    tdm_sync_fsm #(
        .MISS_MAX (MISS_MAX)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (din_valid),
        .i_sync     (frame_sync),
        .o_slot     (slot),
        .o_wr_slot  (w_wr_slot),
        .o_store_en (w_store_en),
        .o_load     (w_load),
        .o_deliver  (w_deliver),
        .o_drop     (w_drop),
        .o_locked   (locked),
        .o_sync_err (sync_err)
    );

    // The last channel comes straight from din so the frame closes on its own beat.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            if (gi < NCH - 1) begin : g_shadow
                assign w_wr_hit[gi] = w_store_en && (w_wr_slot == SLOT_W'(gi));
                assign w_frame[ch_lo(gi, WIDTH) +: WIDTH] = r_shadow[gi];
            end else begin : g_last
                assign w_frame[ch_lo(gi, WIDTH) +: WIDTH] = din;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH - 1; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH - 1; i++) begin
                if (w_drop) begin
                    r_shadow[i] <= '0;
                end else if (w_wr_hit[i]) begin
                    r_shadow[i] <= din;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_data     <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_deliver;
            if (w_load) begin
                r_ch_data <= w_frame;
            end
        end
    end

    assign ch_data     = r_ch_data;
    assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus a randomized run,
// all checked against a frame-level behavioural model.
module tb_tdm_demux4;

    localparam int M_HUNT   = 0;
    localparam int M_SYNC   = 1;
    localparam int M_LOCK   = 2;
    localparam int MISS_MAX = 3;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        frame_sync;
    logic [31:0] ch_data;
    logic        frame_valid;
    logic [1:0]  slot;
    logic        locked;
    logic        sync_err;

    logic        din1;
    logic        din_valid1;
    logic        frame_sync1;
    logic [3:0]  ch_data1;
    logic        frame_valid1;
    logic [1:0]  slot1;
    logic        locked1;
    logic        sync_err1;

    int n_cmp;
    int n_bad;

    // Reference model state
    int          m_state;
    int          m_slot;
    int          m_miss;
    logic [7:0]  m_frame[$];
    logic [31:0] exp_ch;
    logic        exp_fv;
    logic        exp_err;
    logic        exp_locked;

    tdm_demux4 #(.WIDTH(8), .MISS_MAX(MISS_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch_data     (ch_data),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    tdm_demux4 #(.WIDTH(1), .MISS_MAX(MISS_MAX)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .din         (din1),
        .din_valid   (din_valid1),
        .frame_sync  (frame_sync1),
        .ch_data     (ch_data1),
        .frame_valid (frame_valid1),
        .slot        (slot1),
        .locked      (locked1),
        .sync_err    (sync_err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = M_HUNT;
        m_slot  = 0;
        m_miss  = 0;
        m_frame.delete();
        exp_ch     = '0;
        exp_fv     = 1'b0;
        exp_err    = 1'b0;
        exp_locked = 1'b0;
    endtask

    task automatic begin_frame(input logic [7:0] d);
        m_frame.delete();
        m_frame.push_back(d);
        m_slot = 1;
    endtask

    // Applies the receiver rules to one clock edge.
    task automatic model_edge(input bit v, input bit s, input logic [7:0] d);
        exp_fv     = 1'b0;
        exp_err    = 1'b0;
        exp_locked = (m_state == M_LOCK);
        if (!v) return;
        if (m_state == M_HUNT) begin
            if (s) begin
                begin_frame(d);
                m_state = M_SYNC;
            end
        end else if (s && m_slot != 0) begin
            exp_err = 1'b1;
            begin_frame(d);
            m_state = M_SYNC;
            m_miss  = 0;
        end else if (m_slot == 0) begin
            if (s) begin
                m_state = M_LOCK;
                m_miss  = 0;
                begin_frame(d);
            end else if (m_state == M_SYNC) begin
                m_state = M_HUNT;
            end else begin
                m_miss++;
                if (m_miss >= MISS_MAX) begin
                    m_state = M_HUNT;
                    m_miss  = 0;
                end else begin
                    begin_frame(d);
                end
            end
        end else begin
            m_frame.push_back(d);
            m_slot++;
            if (m_slot == 4) begin
                exp_ch = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
                exp_fv = (m_state == M_LOCK);
                m_slot = 0;
            end
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [7:0] d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        model_edge(v, s, d);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = '0; din_valid = 1'b0; frame_sync = 1'b0;
        din1 = 1'b0; din_valid1 = 1'b0; frame_sync1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if (ch_data !== 32'h0 || frame_valid !== 1'b0 || slot !== 2'd0 || locked !== 1'b0 || sync_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: ch_data=%h fv=%b slot=%0d locked=%b err=%b, required all zero",
                     ch_data, frame_valid, slot, locked, sync_err);
        end
        $display("reset: ch_data=%h slot=%0d locked=%b", ch_data, slot, locked);
    endtask

    task automatic test_lock_acq();
        int fv_n = 0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b1, k == 0, 8'h10 + 8'(k));
                if (frame_valid) fv_n++;
                n_cmp++;
                if (frame_valid !== exp_fv || ch_data !== exp_ch) begin
                    n_bad++;
                    $display("FAIL lock_acq f%0d k%0d: fv=%b ch=%h, required fv=%b ch=%h",
                             f, k, frame_valid, ch_data, exp_fv, exp_ch);
                end
            end
            $display("lock_acq frame %0d: ch_data=%h locked=%b", f, ch_data, locked);
        end
        n_cmp++;
        if (fv_n != 2 || ch_data !== 32'h13121110 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_acq_summary: fv_count=%0d ch=%h locked=%b, required 2 13121110 1",
                     fv_n, ch_data, locked);
        end
    endtask

    task automatic test_gapped();
        int fv_n = 0;
        test_reset();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b1, k == 0, 8'h10 + 8'(k));
                if (frame_valid) fv_n++;
                for (int g = 0; g < 2; g++) begin
                    step(1'b0, 1'b1, 8'hEE);
                    n_cmp++;
                    if (slot !== 2'(m_slot) || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
                        n_bad++;
                        $display("FAIL gapped_hold f%0d k%0d: slot=%0d fv=%b err=%b, required slot=%0d fv=0 err=0",
                                 f, k, slot, frame_valid, sync_err, m_slot);
                    end
                end
            end
            $display("gapped frame %0d: ch_data=%h slot=%0d", f, ch_data, slot);
        end
        n_cmp++;
        if (fv_n != 2 || ch_data !== 32'h13121110 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL gapped_summary: fv_count=%0d ch=%h locked=%b, required 2 13121110 1",
                     fv_n, ch_data, locked);
        end
    endtask

    task automatic test_flywheel();
        int fv_n = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b1, 1'b0, 8'h50 + 8'(4 * f + k));
                if (frame_valid) fv_n++;
            end
            n_cmp++;
            if (locked !== 1'b1 || ch_data !== exp_ch) begin
                n_bad++;
                $display("FAIL flywheel_keep f%0d: locked=%b ch=%h, required 1 %h", f, locked, ch_data, exp_ch);
            end
            $display("flywheel frame %0d: ch_data=%h locked=%b", f, ch_data, locked);
        end
        n_cmp++;
        if (fv_n != 2) begin
            n_bad++;
            $display("FAIL flywheel_delivered: fv_count=%0d, required 2", fv_n);
        end
        fv_n = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 8'h60 + 8'(k));
            if (frame_valid) fv_n++;
            if (k == 1) begin
                n_cmp++;
                if (locked !== 1'b0) begin
                    n_bad++;
                    $display("FAIL lock_loss: locked=%b, required 0", locked);
                end
            end
        end
        n_cmp++;
        if (fv_n != 0 || slot !== 2'd0) begin
            n_bad++;
            $display("FAIL lock_loss_hunt: fv_count=%0d slot=%0d, required 0 0", fv_n, slot);
        end
        $display("flywheel lost lock: locked=%b slot=%0d", locked, slot);
    endtask

    task automatic test_misplaced();
        int fv_n  = 0;
        int err_n = 0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 4; k++)
                step(1'b1, k == 0, 8'h40 + 8'(k));
        for (int k = 0; k < 10; k++) begin
            step(1'b1, (k == 0) || (k == 2) || (k == 6), 8'h20 + 8'(k));
            if (frame_valid) fv_n++;
            if (sync_err) err_n++;
            n_cmp++;
            if (sync_err !== exp_err || frame_valid !== exp_fv || ch_data !== exp_ch) begin
                n_bad++;
                $display("FAIL misplaced k%0d: err=%b fv=%b ch=%h, required err=%b fv=%b ch=%h",
                         k, sync_err, frame_valid, ch_data, exp_err, exp_fv, exp_ch);
            end
            if (k == 3) begin
                n_cmp++;
                if (locked !== 1'b0) begin
                    n_bad++;
                    $display("FAIL misplaced_unlock: locked=%b, required 0", locked);
                end
            end
        end
        $display("misplaced: err_count=%0d fv_count=%0d ch_data=%h locked=%b", err_n, fv_n, ch_data, locked);
        n_cmp++;
        if (err_n != 1 || fv_n != 1 || ch_data !== 32'h29282726 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL misplaced_summary: err=%0d fv=%0d ch=%h locked=%b, required 1 1 29282726 1",
                     err_n, fv_n, ch_data, locked);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 8'hA0);
        step(1'b1, 1'b0, 8'hA1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (ch_data !== 32'h0 || frame_valid !== 1'b0 || slot !== 2'd0 || locked !== 1'b0 || sync_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_async: ch=%h fv=%b slot=%0d locked=%b err=%b, required all zero",
                     ch_data, frame_valid, slot, locked, sync_err);
        end
        rst = 1'b0;
        $display("reset_mid: ch_data=%h slot=%0d locked=%b", ch_data, slot, locked);
        step(1'b1, 1'b0, 8'hA2);
        step(1'b1, 1'b0, 8'hA3);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, k == 0, 8'h30 + 8'(k));
            n_cmp++;
            if (slot !== 2'(m_slot)) begin
                n_bad++;
                $display("FAIL reset_mid_slot k%0d: slot=%0d, required %0d", k, slot, m_slot);
            end
        end
        n_cmp++;
        if (ch_data !== 32'h33323130 || frame_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_frame: ch=%h fv=%b, required 33323130 0", ch_data, frame_valid);
        end
    endtask

    task automatic test_width1();
        int fv_n = 0;
        bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        test_reset();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                din1 = pat[k];
                din_valid1 = 1'b1;
                frame_sync1 = (k == 0);
                step(1'b0, 1'b0, 8'h00);
                if (frame_valid1) fv_n++;
            end
        end
        din_valid1 = 1'b0;
        frame_sync1 = 1'b0;
        $display("width1: ch_data=%b fv_count=%0d locked=%b", ch_data1, fv_n, locked1);
        n_cmp++;
        if (ch_data1 !== 4'b1101 || fv_n != 2 || locked1 !== 1'b1) begin
            n_bad++;
            $display("FAIL width1: ch=%b fv_count=%0d locked=%b, required 1101 2 1", ch_data1, fv_n, locked1);
        end
    endtask

    task automatic test_random();
        int bad_here = 0;
        int fv_n = 0;
        test_reset();
        for (int i = 0; i < 800; i++) begin
            bit v;
            bit s;
            int r;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            s = (m_slot == 0) ? (r < 80) : (r < 4);
            step(v, s, 8'($urandom));
            if (frame_valid) fv_n++;
            n_cmp++;
            if (ch_data !== exp_ch || frame_valid !== exp_fv || sync_err !== exp_err ||
                locked !== exp_locked || slot !== 2'(m_slot)) begin
                n_bad++;
                bad_here++;
                $display("FAIL random i%0d: ch=%h fv=%b err=%b lk=%b slot=%0d, required ch=%h fv=%b err=%b lk=%b slot=%0d",
                         i, ch_data, frame_valid, sync_err, locked, slot,
                         exp_ch, exp_fv, exp_err, exp_locked, m_slot);
            end
        end
        $display("random: 800 cycles, frames delivered=%0d, errors=%0d", fv_n, bad_here);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        model_reset();
        test_reset();
        test_lock_acq();
        test_gapped();
        test_flywheel();
        test_misplaced();
        test_reset_mid();
        test_width1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
